// File: rtl/generating_frequencies.sv
// generating_frequencies: stepped-frequency square-wave source.
// q cycles through four half-period lengths (DIV0..DIV3). Each length is held
// for REPEAT full periods and then the schedule advances, wrapping after stage 3.
// Every period is high first and low last. Stage changes therefore always land
// on a falling edge of q, which keeps the output free of runt pulses.
module generating_frequencies #(
    parameter int DIV0   = 1,
    parameter int DIV1   = 2,
    parameter int DIV2   = 4,
    parameter int DIV3   = 8,
    parameter int REPEAT = 4
) (
    input  logic clk,
    input  logic reset_n,  // active-high despite the name: 1 means reset
    output logic q
);

    localparam int MAX01  = (DIV0 > DIV1) ? DIV0 : DIV1;
    localparam int MAX23  = (DIV2 > DIV3) ? DIV2 : DIV3;
    localparam int MAXDIV = (MAX01 > MAX23) ? MAX01 : MAX23;
    localparam int HW     = (MAXDIV > 1) ? $clog2(MAXDIV) : 1;
    localparam int PW     = (REPEAT > 1) ? $clog2(REPEAT) : 1;

    localparam logic [PW-1:0] PCNT_LAST = PW'(REPEAT - 1);

    // Last hcnt value of a half-period in the given stage (DIV - 1).
    function automatic logic [HW-1:0] half_last(input logic [1:0] s);
        case (s)
            2'd0:    return HW'(DIV0 - 1);
            2'd1:    return HW'(DIV1 - 1);
            2'd2:    return HW'(DIV2 - 1);
            default: return HW'(DIV3 - 1);
        endcase
    endfunction

    logic [1:0]    stage;
    logic [HW-1:0] hcnt;
    logic [PW-1:0] pcnt;
    logic          toggle;

    // A half-period ends when hcnt reaches DIV-1 of the current stage.
    always_comb begin
        toggle = (hcnt == half_last(stage));
    end

    // Half-period counting, q toggling, and period/stage bookkeeping.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            q     <= 1'b0;
            stage <= 2'd0;
            hcnt  <= '0;
            pcnt  <= '0;
        end else if (!toggle) begin
            hcnt <= hcnt + 1'b1;
        end else begin
            hcnt <= '0;
            q    <= ~q;
            // A falling toggle closes a full period.
            if (q) begin
                if (pcnt == PCNT_LAST) begin
                    pcnt  <= '0;
                    stage <= stage + 2'd1;
                end else begin
                    pcnt <= pcnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_generating_frequencies.sv
// Directed bench for generating_frequencies: default instance plus a
// DIV=3,1,2,5 / REPEAT=1 variant, both checked against hand-derived patterns.
module tb_generating_frequencies;

    logic clk;
    logic rst;
    logic rst_v;
    logic q;
    logic q_v;

    int n_cmp = 0;
    int n_bad = 0;

    generating_frequencies dut (
        .clk     (clk),
        .reset_n (rst),
        .q       (q)
    );

    generating_frequencies #(
        .DIV0   (3),
        .DIV1   (1),
        .DIV2   (2),
        .DIV3   (5),
        .REPEAT (1)
    ) dut_v (
        .clk     (clk),
        .reset_n (rst_v),
        .q       (q_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Variant expected q after edges 1..22 of its 22-cycle sweep.
    int vexp [22] = '{0,0,1,1,1,0,1,0,0,1,1,0,0,0,0,0,1,1,1,1,1,0};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Default-parameter expectation for q after edge n (n >= 1), from the stage
    // window table: stage starts at edge s0 with half-period d; q after the
    // k-th edge of the stage equals the parity of floor(k/d).
    function automatic logic exp_def(input int n);
        int m, s0, d, k;
        m = ((n - 1) % 120) + 1;
        if (m <= 8)       begin s0 = 1;  d = 1; end
        else if (m <= 24) begin s0 = 9;  d = 2; end
        else if (m <= 56) begin s0 = 25; d = 4; end
        else              begin s0 = 57; d = 8; end
        k = m - s0 + 1;
        return ((k / d) % 2) == 1;
    endfunction

    initial begin
        int highs;
        int vhighs;
        rst   = 1'b1;
        rst_v = 1'b1;

        // Reset hold for three edges.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_val($sformatf("reset_q_%0d", i), 32'(q), 32'd0);
            check_val($sformatf("reset_qv_%0d", i), 32'(q_v), 32'd0);
        end

        rst   = 1'b0;
        rst_v = 1'b0;

        // Two full default sweeps (edges 1..240); variant runs alongside.
        highs  = 0;
        vhighs = 0;
        for (int n = 1; n <= 240; n++) begin
            @(posedge clk);
            @(negedge clk);
            check_val($sformatf("q_edge_%0d", n), 32'(q), 32'(exp_def(n)));
            if (q) highs++;
            if (n % 120 == 0) begin
                check_val($sformatf("high_count_sweep_%0d", n / 120), 32'(highs), 32'd60);
                highs = 0;
            end
            if (n <= 44) begin
                check_val($sformatf("qv_edge_%0d", n), 32'(q_v), 32'(vexp[(n - 1) % 22]));
                if (q_v) vhighs++;
                if (n % 22 == 0) begin
                    check_val($sformatf("qv_high_count_%0d", n / 22), 32'(vhighs), 32'd11);
                    vhighs = 0;
                end
            end
        end

        // Continue into stage 2 of the third sweep (edges 241..278).
        for (int n = 241; n <= 278; n++) begin
            @(posedge clk);
            @(negedge clk);
            check_val($sformatf("q_edge_%0d", n), 32'(q), 32'(exp_def(n)));
        end
        check_val("pre_mid_reset_high", 32'(q), 32'd1);

        // Mid-stage reset during a stage-2 high phase.
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("mid_reset_q", 32'(q), 32'd0);
        rst = 1'b0;

        // Schedule restarts at stage 0.
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk);
            @(negedge clk);
            check_val($sformatf("restart_edge_%0d", n), 32'(q), 32'(n % 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
